if2_fetch_buffer: RTL and testbench

IF2_FETCH_BUFFER -- requirements
Module: if2_fetch_buffer

---
 rtl/if2_fetch_buffer_pkg.sv | 19 +
 rtl/if2_fetch_buffer.sv | 154 +++++++++++++++
 tb/tb_if2_fetch_buffer.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/if2_fetch_buffer_pkg.sv
// rtl/if2_fetch_buffer_pkg.sv - shared core types and constants for the IF2 fetch buffer
// Contents: fetch_entry_t (one buffered fetch), NOP_INST, DROP_W (width of the
// discard counter for responses belonging to flushed fetches).
package if2_fetch_buffer_pkg;

    localparam logic [31:0] NOP_INST = 32'h00000013;

    // Several flushes can stack discards while memory is slow, so this is
    // wider than the queue occupancy.
    localparam int DROP_W = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        filled;
        logic        fault;
    } fetch_entry_t;

endpackage

// File: rtl/if2_fetch_buffer.sv
// rtl/if2_fetch_buffer.sv - IF2 stage fetch queue between IF1 PC, instruction memory and decode
// Ports:
//   clk, reset_n                       clock, asynchronous active-low reset
//   pc_if1, pc_valid_if1, pc_ready_if1 fetch address in; ready is the PC enable
//   imem_req, imem_addr, imem_gnt      memory request channel
//   imem_rvalid, imem_rdata            in-order memory response channel
//   flush_if2                          redirect: drop buffered and in-flight fetches
//   valid_if2, ready_id                head handshake towards decode
//   inst_if2, pc_if2, fault_if2        head entry contents
// Optional macros:
//   IF2_MISALIGN_TRAP_EN  misaligned PCs become filled fault entries, never sent to memory
//   IF2_DV                checks that every response has an outstanding request
module if2_fetch_buffer
    import if2_fetch_buffer_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] pc_if1,
    input  logic        pc_valid_if1,
    output logic        pc_ready_if1,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        flush_if2,
    output logic        valid_if2,
    input  logic        ready_id,
    output logic [31:0] inst_if2,
    output logic [31:0] pc_if2,
    output logic        fault_if2
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    fetch_entry_t       entries [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [OCC_W-1:0]   occ;
    // Memory requests whose entries are still live (excludes discards).
    logic [OCC_W-1:0]   pending;
    logic [DROP_W-1:0]  drop_cnt;

    logic               space;
    logic               misaligned;
    logic               mem_hs;
    logic               trap_alloc;
    logic               pop;
    logic               rsp_known;
    logic               rsp_drop;
    logic               rsp_take;
    logic [PTR_W-1:0]   fill_idx;
    logic               fill_found;
    fetch_entry_t       new_entry;

    always_comb begin
        space = (occ < FULL_OCC);
`ifdef IF2_MISALIGN_TRAP_EN
        misaligned = pc_valid_if1 & (pc_if1[1:0] != 2'b00);
`else
        misaligned = 1'b0;
`endif
        // Gated by reset_n so nothing is offered while reset is held.
        imem_req     = reset_n & pc_valid_if1 & space & ~flush_if2 & ~misaligned;
        trap_alloc   = reset_n & misaligned & space & ~flush_if2;
        mem_hs       = imem_req & imem_gnt;
        pc_ready_if1 = mem_hs | trap_alloc;
        imem_addr    = pc_if1;

        valid_if2 = (occ != '0) & entries[head].filled;
        pop       = valid_if2 & ready_id;
        inst_if2  = entries[head].inst;
        pc_if2    = entries[head].pc;
`ifdef IF2_MISALIGN_TRAP_EN
        fault_if2 = valid_if2 & entries[head].fault;
`else
        fault_if2 = 1'b0;
`endif

        // A response with nothing outstanding is ignored entirely.
        rsp_known = imem_rvalid & ((drop_cnt != '0) | (pending != '0));
        rsp_drop  = rsp_known & (drop_cnt != '0);
        rsp_take  = rsp_known & (drop_cnt == '0);

        new_entry.pc     = pc_if1;
        new_entry.inst   = 32'h0;
        new_entry.filled = trap_alloc;
        new_entry.fault  = trap_alloc;
    end

    // Responses are in order, but trap entries are filled at allocation,
    // so the target is the first unfilled live entry walking from head.
    always_comb begin
        fill_idx   = head;
        fill_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_found && (OCC_W'(i) < occ) && !entries[head + PTR_W'(i)].filled) begin
                fill_idx   = head + PTR_W'(i);
                fill_found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            pending  <= '0;
            drop_cnt <= '0;
        end else if (flush_if2) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries[i] <= '0;
            end
            head     <= '0;
            tail     <= '0;
            occ      <= '0;
            pending  <= '0;
            // A response arriving with the flush retires one of the
            // outstanding requests immediately.
            drop_cnt <= drop_cnt + DROP_W'(pending) - DROP_W'(rsp_known);
        end else begin
            if (pc_ready_if1) begin
                entries[tail] <= new_entry;
                tail          <= tail + 1'b1;
            end
            if (rsp_take && fill_found) begin
                entries[fill_idx].inst   <= imem_rdata;
                entries[fill_idx].filled <= 1'b1;
            end
            if (rsp_drop) begin
                drop_cnt <= drop_cnt - 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            occ     <= occ + OCC_W'(pc_ready_if1) - OCC_W'(pop);
            pending <= pending + OCC_W'(mem_hs) - OCC_W'(rsp_take);
        end
    end

`ifdef IF2_DV
    a_rvalid_outstanding: assert property (@(posedge clk) disable iff (!reset_n)
        imem_rvalid |-> ((drop_cnt != '0) || (pending != '0)));
`endif

endmodule

// File: tb/tb_if2_fetch_buffer.sv
// tb/tb_if2_fetch_buffer.sv - self-checking bench for if2_fetch_buffer
module tb_if2_fetch_buffer;
    import if2_fetch_buffer_pkg::*;

    localparam int DEPTH = 2;
`ifdef IF2_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] pc_if1;
    logic        pc_valid_if1;
    logic        pc_ready_if1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        flush_if2;
    logic        valid_if2;
    logic        ready_id;
    logic [31:0] inst_if2;
    logic [31:0] pc_if2;
    logic        fault_if2;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    if2_fetch_buffer #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .pc_if1       (pc_if1),
        .pc_valid_if1 (pc_valid_if1),
        .pc_ready_if1 (pc_ready_if1),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .flush_if2    (flush_if2),
        .valid_if2    (valid_if2),
        .ready_id     (ready_id),
        .inst_if2     (inst_if2),
        .pc_if2       (pc_if2),
        .fault_if2    (fault_if2)
    );

    task automatic idle();
        pc_valid_if1 = 1'b0;
        pc_if1       = 32'h0;
        imem_gnt     = 1'b0;
        imem_rvalid  = 1'b0;
        imem_rdata   = 32'h0;
        flush_if2    = 1'b0;
        ready_id     = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        #1;
    endtask

    task automatic fetch(input logic [31:0] pc);
        pc_if1 = pc; pc_valid_if1 = 1'b1; imem_gnt = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 1'b0;
        pc_valid_if1 = 1'b1; imem_gnt = 1'b1; pc_if1 = 32'h100;
        #2;
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %0b want 0", imem_req); end
        vectors++; if (pc_ready_if1 !== 1'b0) begin miscompares++; $display("FAIL reset_pc_ready: got %0b want 0", pc_ready_if1); end
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %0b want 0", valid_if2); end
        vectors++; if (inst_if2 !== 32'h0) begin miscompares++; $display("FAIL reset_inst: got %h want 0", inst_if2); end
        vectors++; if (pc_if2 !== 32'h0) begin miscompares++; $display("FAIL reset_pc: got %h want 0", pc_if2); end
        vectors++; if (fault_if2 !== 1'b0) begin miscompares++; $display("FAIL reset_fault: got %0b want 0", fault_if2); end
        do_reset();
    endtask

    task automatic test_single_fetch();
        do_reset();
        next_cycle(); fetch(32'hfffff000); #1;
        vectors++; if (imem_req !== 1'b1) begin miscompares++; $display("FAIL single_req: got %0b want 1", imem_req); end
        vectors++; if (imem_addr !== 32'hfffff000) begin miscompares++; $display("FAIL single_addr: got %h want fffff000", imem_addr); end
        vectors++; if (pc_ready_if1 !== 1'b1) begin miscompares++; $display("FAIL single_pc_ready: got %0b want 1", pc_ready_if1); end
        next_cycle(); idle(); imem_rvalid = 1'b1; imem_rdata = NOP_INST; #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL single_early_valid: got %0b want 0", valid_if2); end
        next_cycle(); idle(); ready_id = 1'b1; #1;
        vectors++; if (valid_if2 !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b want 1", valid_if2); end
        vectors++; if (pc_if2 !== 32'hfffff000) begin miscompares++; $display("FAIL single_pc: got %h want fffff000", pc_if2); end
        vectors++; if (inst_if2 !== NOP_INST) begin miscompares++; $display("FAIL single_inst: got %h want %h", inst_if2, NOP_INST); end
        next_cycle(); idle(); #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL single_popped: got %0b want 0", valid_if2); end
    endtask

    task automatic test_back_pressure();
        do_reset();
        next_cycle(); fetch(32'h1000); #1;
        vectors++; if (pc_ready_if1 !== 1'b1) begin miscompares++; $display("FAIL bp_accept0: got %0b want 1", pc_ready_if1); end
        next_cycle(); fetch(32'h1004); imem_rvalid = 1'b1; imem_rdata = 32'haaaa0001; #1;
        vectors++; if (pc_ready_if1 !== 1'b1) begin miscompares++; $display("FAIL bp_accept1: got %0b want 1", pc_ready_if1); end
        next_cycle(); fetch(32'h1008); imem_rvalid = 1'b1; imem_rdata = 32'haaaa0002; #1;
        vectors++; if (pc_ready_if1 !== 1'b0) begin miscompares++; $display("FAIL bp_full_ready: got %0b want 0", pc_ready_if1); end
        vectors++; if (imem_req !== 1'b0) begin miscompares++; $display("FAIL bp_full_req: got %0b want 0", imem_req); end
        vectors++; if (valid_if2 !== 1'b1 || pc_if2 !== 32'h1000) begin miscompares++; $display("FAIL bp_head: got v=%0b pc=%h want v=1 pc=1000", valid_if2, pc_if2); end
        next_cycle(); imem_rvalid = 1'b0; #1;
        vectors++; if (pc_if2 !== 32'h1000 || inst_if2 !== 32'haaaa0001) begin miscompares++; $display("FAIL bp_hold: got pc=%h inst=%h want 1000 aaaa0001", pc_if2, inst_if2); end
        ready_id = 1'b1; #1;
        vectors++; if (pc_ready_if1 !== 1'b0) begin miscompares++; $display("FAIL bp_full_with_pop: got %0b want 0", pc_ready_if1); end
        next_cycle(); pc_valid_if1 = 1'b0; #1;
        vectors++; if (valid_if2 !== 1'b1 || pc_if2 !== 32'h1004 || inst_if2 !== 32'haaaa0002) begin miscompares++; $display("FAIL bp_second: got v=%0b pc=%h inst=%h want 1 1004 aaaa0002", valid_if2, pc_if2, inst_if2); end
        next_cycle(); idle(); #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL bp_empty: got %0b want 0", valid_if2); end
    endtask

    task automatic test_flush_in_flight();
        do_reset();
        next_cycle(); fetch(32'h100);
        next_cycle(); fetch(32'h104);
        next_cycle(); fetch(32'h108); flush_if2 = 1'b1; #1;
        vectors++; if (imem_req !== 1'b0 || pc_ready_if1 !== 1'b0) begin miscompares++; $display("FAIL flush_gate: got req=%0b rdy=%0b want 0 0", imem_req, pc_ready_if1); end
        next_cycle(); flush_if2 = 1'b0; fetch(32'h80000000); imem_rvalid = 1'b1; imem_rdata = 32'hdead0001; #1;
        vectors++; if (pc_ready_if1 !== 1'b1) begin miscompares++; $display("FAIL flush_accept_after: got %0b want 1", pc_ready_if1); end
        next_cycle(); pc_valid_if1 = 1'b0; imem_gnt = 1'b0; imem_rdata = 32'hdead0002; #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL flush_drop1: got %0b want 0", valid_if2); end
        next_cycle(); imem_rdata = 32'h11111111; #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL flush_drop2: got %0b want 0", valid_if2); end
        next_cycle(); imem_rvalid = 1'b0; ready_id = 1'b1; #1;
        vectors++; if (valid_if2 !== 1'b1 || pc_if2 !== 32'h80000000 || inst_if2 !== 32'h11111111) begin miscompares++; $display("FAIL flush_refetch: got v=%0b pc=%h inst=%h want 1 80000000 11111111", valid_if2, pc_if2, inst_if2); end
        next_cycle(); idle(); #1;
    endtask

    task automatic test_flush_with_rvalid();
        do_reset();
        next_cycle(); fetch(32'h200);
        next_cycle(); fetch(32'h204);
        next_cycle(); idle(); flush_if2 = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hbad00001; #1;
        next_cycle(); flush_if2 = 1'b0; imem_rdata = 32'hbad00002; #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL fr_empty: got %0b want 0", valid_if2); end
        next_cycle(); imem_rvalid = 1'b0; fetch(32'h300); #1;
        vectors++; if (valid_if2 !== 1'b0 || pc_ready_if1 !== 1'b1) begin miscompares++; $display("FAIL fr_after: got v=%0b rdy=%0b want 0 1", valid_if2, pc_ready_if1); end
        next_cycle(); idle(); imem_rvalid = 1'b1; imem_rdata = 32'h22222222; #1;
        next_cycle(); idle(); ready_id = 1'b1; #1;
        vectors++; if (valid_if2 !== 1'b1 || pc_if2 !== 32'h300 || inst_if2 !== 32'h22222222) begin miscompares++; $display("FAIL fr_refetch: got v=%0b pc=%h inst=%h want 1 300 22222222", valid_if2, pc_if2, inst_if2); end
        next_cycle(); idle(); #1;
        vectors++; if (valid_if2 !== 1'b0) begin miscompares++; $display("FAIL fr_drained: got %0b want 0", valid_if2); end
    endtask

`ifdef IF2_MISALIGN_TRAP_EN
    task automatic test_misalign();
        do_reset();
        next_cycle(); pc_if1 = 32'h80000002; pc_valid_if1 = 1'b1; imem_gnt = 1'b0; #1;
        vectors++; if (imem_req !== 1'b0 || pc_ready_if1 !== 1'b1) begin miscompares++; $display("FAIL mis_req: got req=%0b rdy=%0b want 0 1", imem_req, pc_ready_if1); end
        next_cycle(); idle(); ready_id = 1'b1; #1;
        vectors++; if (valid_if2 !== 1'b1 || fault_if2 !== 1'b1 || pc_if2 !== 32'h80000002 || inst_if2 !== 32'h0) begin miscompares++; $display("FAIL mis_entry: got v=%0b f=%0b pc=%h inst=%h want 1 1 80000002 0", valid_if2, fault_if2, pc_if2, inst_if2); end
        next_cycle(); idle(); #1;
    endtask
`endif

    task automatic test_reset_mid();
        do_reset();
        next_cycle(); fetch(32'h400);
        next_cycle(); fetch(32'h404); imem_rvalid = 1'b1; imem_rdata = 32'h33330001;
        next_cycle(); idle(); imem_rvalid = 1'b1; imem_rdata = 32'h33330002;
        next_cycle(); idle(); #1;
        vectors++; if (valid_if2 !== 1'b1) begin miscompares++; $display("FAIL rm_filled: got %0b want 1", valid_if2); end
        #1; reset_n = 1'b0; pc_valid_if1 = 1'b1; imem_gnt = 1'b1; #1;
        vectors++; if (valid_if2 !== 1'b0 || imem_req !== 1'b0 || pc_ready_if1 !== 1'b0) begin miscompares++; $display("FAIL rm_immediate: got v=%0b req=%0b rdy=%0b want 0 0 0", valid_if2, imem_req, pc_ready_if1); end
        next_cycle(); next_cycle(); reset_n = 1'b1; idle(); #1;
        vectors++; if (valid_if2 !== 1'b0 || pc_if2 !== 32'h0 || inst_if2 !== 32'h0 || fault_if2 !== 1'b0 || imem_req !== 1'b0 || pc_ready_if1 !== 1'b0) begin miscompares++; $display("FAIL rm_release: got v=%0b pc=%h inst=%h f=%0b req=%0b rdy=%0b want all 0", valid_if2, pc_if2, inst_if2, fault_if2, imem_req, pc_ready_if1); end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        bit          filled;
        bit          fault;
    } m_ent_t;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5a5ac3c3;
    endfunction

    task automatic test_random(input int cycles);
        m_ent_t      mq[$];
        m_ent_t      ne;
        logic [31:0] mem_q[$];
        int          drop;
        int          unfilled;
        bit          space, mis, e_req, e_rdy, e_valid, done;
        do_reset();
        drop = 0;
        next_cycle();
        for (int c = 0; c < cycles; c++) begin
            pc_valid_if1 = ($urandom_range(0, 3) != 0);
            pc_if1       = $urandom;
            if ($urandom_range(0, 7) != 0) pc_if1[1:0] = 2'b00;
            imem_gnt     = 1'($urandom_range(0, 1));
            ready_id     = ($urandom_range(0, 2) != 0);
            flush_if2    = ($urandom_range(0, 24) == 0);
            imem_rvalid  = 1'b0;
            imem_rdata   = $urandom;
            if (mem_q.size() > 0 && $urandom_range(0, 2) != 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mem_q.pop_front());
            end else if (mem_q.size() == 0 && $urandom_range(0, 49) == 0) begin
                imem_rvalid = 1'b1;
            end
            #1;
            space   = (mq.size() < DEPTH);
            mis     = TRAP_EN && pc_valid_if1 && (pc_if1[1:0] != 2'b00);
            e_req   = pc_valid_if1 && space && !flush_if2 && !mis;
            e_rdy   = (e_req && imem_gnt) || (mis && space && !flush_if2);
            e_valid = (mq.size() > 0) && mq[0].filled;
            vectors++; if (imem_req !== e_req) begin miscompares++; $display("FAIL rnd_req c=%0d: got %0b want %0b", c, imem_req, e_req); end
            vectors++; if (pc_ready_if1 !== e_rdy) begin miscompares++; $display("FAIL rnd_pc_ready c=%0d: got %0b want %0b", c, pc_ready_if1, e_rdy); end
            vectors++; if (e_req && imem_addr !== pc_if1) begin miscompares++; $display("FAIL rnd_addr c=%0d: got %h want %h", c, imem_addr, pc_if1); end
            vectors++; if (valid_if2 !== e_valid) begin miscompares++; $display("FAIL rnd_valid c=%0d: got %0b want %0b", c, valid_if2, e_valid); end
            if (e_valid) begin
                vectors++; if (pc_if2 !== mq[0].pc || inst_if2 !== mq[0].inst || fault_if2 !== mq[0].fault) begin miscompares++; $display("FAIL rnd_head c=%0d: got pc=%h inst=%h f=%0b want %h %h %0b", c, pc_if2, inst_if2, fault_if2, mq[0].pc, mq[0].inst, mq[0].fault); end
            end
            @(posedge clk);
            unfilled = 0;
            foreach (mq[i]) if (!mq[i].filled) unfilled++;
            if (flush_if2) begin
                drop = drop + unfilled - ((imem_rvalid && (drop + unfilled) > 0) ? 1 : 0);
                mq.delete();
            end else begin
                if (imem_rvalid) begin
                    if (drop > 0) drop--;
                    else begin
                        done = 1'b0;
                        foreach (mq[i]) if (!done && !mq[i].filled) begin
                            mq[i].inst = imem_rdata; mq[i].filled = 1'b1; done = 1'b1;
                        end
                    end
                end
                if (e_valid && ready_id) void'(mq.pop_front());
                if (e_rdy) begin
                    ne.pc = pc_if1; ne.inst = 32'h0; ne.filled = mis; ne.fault = mis;
                    mq.push_back(ne);
                end
            end
            if (e_req && imem_gnt) mem_q.push_back(pc_if1);
            #1;
        end
        idle();
    endtask

    initial begin
        reset_n = 1'b0;
        idle();
        test_reset();
        test_single_fetch();
        test_back_pressure();
        test_flush_in_flight();
        test_flush_with_rvalid();
`ifdef IF2_MISALIGN_TRAP_EN
        test_misalign();
`endif
        test_reset_mid();
        test_random(3000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
